// File: rtl/decode_if.sv
// Handshake, writeback and status bundle for the decode stage.
// The master side is the environment: upstream producer, downstream consumer and writeback.
interface decode_if #(
  parameter int REG_W = 2
) ();
  localparam int INSTR_W = 2 + 3 * REG_W;
  localparam int FIELD_W = 2 * REG_W;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_opcode;
  logic [REG_W-1:0]   out_rd;
  logic [REG_W-1:0]   out_rs1;
  logic [REG_W-1:0]   out_rs2;
  logic [FIELD_W-1:0] out_addr;
  logic [FIELD_W-1:0] out_imm;
  logic               out_illegal;
  logic               out_writes_rd;
  logic               wb_valid;
  logic [REG_W-1:0]   wb_rd;
  logic               flush;
  logic [15:0]        stall_cnt;

  modport master (
    output in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
           out_addr, out_imm, out_illegal, out_writes_rd, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
    output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
           out_addr, out_imm, out_illegal, out_writes_rd, stall_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// Single-entry decode stage: field extraction, register scoreboard with writeback bypass,
// hazard stalling, flush and a saturating stall counter.
module decode_stage #(
  parameter int REG_W      = 2,
  parameter bit ENABLE_SUB = 1'b0
) (
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);
  localparam int NUM_REGS = 2 ** REG_W;
  localparam int INSTR_W  = 2 + 3 * REG_W;
  localparam int FIELD_W  = 2 * REG_W;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LI    = 2'b10,
    OP_BNER0 = 2'b11
  } opcode_e;

  typedef struct packed {
    opcode_e            opcode;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [FIELD_W-1:0] addr;
    logic [FIELD_W-1:0] imm;
    logic               illegal;
    logic               writes_rd;
  } decoded_t;

  decoded_t            dec;
  decoded_t            held;
  logic                valid_q;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pend_byp;
  logic [NUM_REGS-1:0] pend_next;
  logic                hazard;
  logic                accept;
  logic [15:0]         stall_q;

  // NOTE: every field gets a default before the case, so no path can leave a latch behind.
  always_comb begin
    dec        = '0;
    dec.opcode = opcode_e'(bus.in_instr[INSTR_W-1 -: 2]);
    unique case (dec.opcode)
      OP_ADD, OP_SUB: begin
        if (dec.opcode == OP_ADD || ENABLE_SUB) begin
          dec.rd        = bus.in_instr[3*REG_W-1 -: REG_W];
          dec.rs1       = bus.in_instr[2*REG_W-1 -: REG_W];
          dec.rs2       = bus.in_instr[REG_W-1:0];
          dec.writes_rd = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LI: begin
        dec.rd        = bus.in_instr[3*REG_W-1 -: REG_W];
        dec.imm       = bus.in_instr[FIELD_W-1:0];
        dec.writes_rd = 1'b1;
      end
      OP_BNER0: begin
        dec.addr = bus.in_instr[INSTR_W-3 -: FIELD_W];
        dec.rs2  = bus.in_instr[REG_W-1:0];
      end
    endcase
  end

  // A writeback landing this cycle already frees its register for the hazard check.
  always_comb begin
    pend_byp = pending;
    if (bus.wb_valid) pend_byp[bus.wb_rd] = 1'b0;
    hazard = 1'b0;
    if (!dec.illegal) begin
      unique case (dec.opcode)
        OP_ADD, OP_SUB: hazard = pend_byp[dec.rs1] | pend_byp[dec.rs2] | pend_byp[dec.rd];
        OP_LI:          hazard = pend_byp[dec.rd];
        OP_BNER0:       hazard = pend_byp[dec.rs2] | pend_byp[0];
      endcase
    end
  end

  assign bus.in_ready = !rst && !bus.flush && !hazard && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Set from a new acceptance is applied last so it wins over a same-cycle writeback clear.
  always_comb begin
    pend_next = pend_byp;
    if (bus.flush && valid_q && held.writes_rd) pend_next[held.rd] = 1'b0;
    if (accept && dec.writes_rd) pend_next[dec.rd] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      held    <= '0;
      pending <= '0;
      stall_q <= '0;
    end else begin
      pending <= pend_next;
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        held    <= dec;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (bus.in_valid && hazard && !bus.flush && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.out_opcode    = held.opcode;
  assign bus.out_rd        = held.rd;
  assign bus.out_rs1       = held.rs1;
  assign bus.out_rs2       = held.rs2;
  assign bus.out_addr      = held.addr;
  assign bus.out_imm       = held.imm;
  assign bus.out_illegal   = held.illegal;
  assign bus.out_writes_rd = held.writes_rd;
  assign bus.stall_cnt     = stall_q;
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter REG_W, default 2: register-index width; NUM_REGS = 2**REG_W; INSTR_W = 2+3*REG_W; FIELD_W = 2*REG_W.
REQ-002 Parameter ENABLE_SUB, default 0: 1 = opcode 01 decodes as sub; 0 = opcode 01 is illegal.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  upstream instruction valid.
REQ-006 in_ready  out  1  decode accepts in_instr this cycle.
REQ-007 in_instr  in  INSTR_W  raw instruction.
REQ-008 out_valid  out  1  decoded instruction held.
REQ-009 out_ready  in  1  downstream consumes held instruction.
REQ-010 out_opcode  out  2; out_rd, out_rs1, out_rs2  out  REG_W each; out_addr, out_imm  out  FIELD_W each.
REQ-011 out_illegal  out  1  held instruction has an undefined opcode.
REQ-012 out_writes_rd  out  1  held instruction writes out_rd.
REQ-013 wb_valid  in  1; wb_rd  in  REG_W: writeback completion, clears pending bit wb_rd.
REQ-014 flush  in  1  discard held instruction and block acceptance this cycle.
REQ-015 stall_cnt  out  16  count of hazard-stall cycles.

Function
REQ-016 Fields: opcode=[INSTR_W-1:INSTR_W-2], rd=[3R-1:2R], rs1=[2R-1:R], rs2=[R-1:0], addr=[INSTR_W-3:R], imm=[2R-1:0], where R=REG_W.
REQ-017 Opcode 00 add / 01 sub (ENABLE_SUB=1): rd, rs1, rs2 passed; addr=imm=0; writes_rd=1.
REQ-018 Opcode 10 li: rd, imm passed; rs1=rs2=addr=0; writes_rd=1.
REQ-019 Opcode 11 bner0: addr, rs2 passed; rd=rs1=imm=0; writes_rd=0.
REQ-020 Illegal opcode: out_opcode passed; all other fields 0; out_illegal=1; writes_rd=0; no scoreboard effect.
REQ-021 Scoreboard: NUM_REGS pending bits; pending[rd] sets on acceptance of any instruction with writes_rd=1.
REQ-022 Hazard: add/sub if pending at rs1, rs2 or rd; li if pending at rd; bner0 if pending at rs2 or register 0; illegal never.
REQ-023 Hazard check uses pending bits with the same-cycle wb_rd clear already applied (writeback bypass).
REQ-024 in_ready = !rst && !flush && !hazard(in_instr) && (!out_valid || out_ready), combinational.
REQ-025 Acceptance (in_valid && in_ready) loads output register next edge; latency exactly 1 cycle; out_valid=1.
REQ-026 out_valid && out_ready with no acceptance: out_valid=0 next edge; outputs stable while out_valid && !out_ready.
REQ-027 Same register set by acceptance and cleared by writeback in one cycle: set wins.
REQ-028 flush: out_valid=0 next edge; if held instruction had writes_rd=1, its pending[rd] clears; other pending bits unchanged.
REQ-029 stall_cnt increments each cycle with in_valid && hazard && !flush; saturates at 16'hFFFF.
REQ-030 wb_valid for a register not pending: no effect.

Reset
REQ-031 rst at any cycle, including mid-stall or with held instruction: next edge out_valid=0, all pending bits 0, stall_cnt=0, all decoded outputs 0, held instruction discarded.
REQ-032 During rst, in_ready=0.

Verification
REQ-033 REG_W=2: in 8'b00_01_10_11 accepted -> next cycle out_valid=1, opcode=00, rd=1, rs1=2, rs2=3, addr=0, imm=0, writes_rd=1.
REQ-034 li r1,5 (8'b10_01_0101) then add r2,r1,r1, no writeback -> add stalls, in_ready=0, stall_cnt increments per cycle; wb_valid, wb_rd=1 -> add accepted same cycle.
REQ-035 ENABLE_SUB=0, in 8'b01_xx_xx_xx -> out_illegal=1, fields 0, no pending set; ENABLE_SUB=1 -> sub decoded, pending[rd]=1.
REQ-036 Held li r3 with out_ready=0, flush=1 -> out_valid=0 next cycle, pending[3]=0, in_ready=0 during flush cycle.
REQ-037 out_ready=0 for 4 cycles -> outputs unchanged, in_ready=0; back-to-back accept with out_ready=1 -> one instruction per cycle.
REQ-038 rst asserted with pending bits set and stall_cnt=7 -> next cycle all pending 0, stall_cnt=0, out_valid=0.
